mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage of the five-stage MIPS pipeline. It accepts `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` from the E stage. It models the fixed MIPS latency with a busy counter and commits results to HI/LO on completion. It drives the D-stage stall request that keeps any multiply/divide-class instruction out of E while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `E_mdOp` input 3: operation code from the package.
  - Encodings: `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6; 7 is treated as NONE.
- `E_start` input 1: high for one cycle when a valid mult/multu/div/divu is in E.
- `E_A` input 32: rs operand, already forwarded.
- `E_B` input 32: rt operand, already forwarded.
- `D_isMD` input 1: D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `hi` output 32: current HI register; reset 0.
- `lo` output 32: current LO register; reset 0.
- `busy` output 1: operation in flight; reset 0.
- `md_stall` output 1: combinational, `D_isMD & (E_start | busy)`; reset-state value is 0 because `busy` is 0.

## Operation
- State: `IDLE` and `BUSY`, plus a 4-bit down-counter `cnt`, a pending `{hiNext, loNext}` register and a pending-valid flag.
- `IDLE`:
  - `E_start` with a mult-class op → capture result, set `cnt` = `MULT_CYCLES`, go to `BUSY`.
  - `E_start` with a div-class op → capture result, set `cnt` = `DIV_CYCLES`, go to `BUSY`.
- `BUSY`:
  - Decrement `cnt` every cycle.
  - When `cnt` == 1: commit the pending value to HI/LO, go to `IDLE`.
- Result arithmetic is computed at capture from `E_A`/`E_B` as sampled on the start edge:
  - `mult`: signed 32×32→64; `{hi,lo}` = product.
  - `multu`: unsigned 32×32→64; `{hi,lo}` = product.
  - `div`: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
  - `divu`: unsigned quotient and remainder.
  - Divide by zero (`E_B`==0): the operation still occupies `DIV_CYCLES`, but HI/LO are left unchanged at commit (pending-valid cleared).
  - `div` of 0x80000000 by 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- `mthi`/`mtlo` (no `E_start`): in `IDLE`, write `E_A` into HI/LO at the next edge. No busy cycles. Never issued while `BUSY`, because the stall guarantees it.
- `E_start` while `BUSY`: ignored, state unaffected. This is illegal; the bench flags it with an assertion.
- `E_start` with op NONE/MTHI/MTLO/7: no operation started.
- Reset mid-operation: immediately returns to `IDLE`, `cnt`=0, HI=LO=0, pending discarded.

## Timing
- `E_start` sampled at edge k.
- `busy` is high during cycles k+1 … k+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO update at edge k+N. `busy` falls at the same edge.
- `mfhi`/`mflo` entering E in cycle k+N+1 reads the new value.
- `md_stall` covers the start cycle itself, via `E_start`, and all N busy cycles: N+1 stall cycles for a D-stage MD instruction directly behind the start.
- `mthi`/`mtlo`: HI/LO are visible at `hi`/`lo` one cycle after E.
- `hi`/`lo` are register outputs with no combinational path from the inputs. `md_stall` is combinational from `D_isMD`, `E_start` and `busy`.

## Structure
- Shared package `md_defs`: `MD_*` op encodings, default cycle constants, and a `md_state_t` enum (`IDLE`, `BUSY`).
- The opcode/funct decode that produces `E_mdOp`, `E_start` and `D_isMD` extends the existing Controller. It lives there, not in this block.
- Optional sub-module `md_arith`: purely combinational 64-bit result for the four arithmetic ops, including the divide-by-zero flag. The FSM, counter and HI/LO registers stay in `mult_div_unit`.

## Test plan
- `mult` with A=0xFFFFFFFF (−1), B=3 → `busy` high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFD. Same operands with `multu` → hi=0x00000002, lo=0xFFFFFFFD.
- `div` with A=−7 (0xFFFFFFF9), B=2 → `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. `divu` with A=7, B=2 → lo=3, hi=1.
- `div` with B=0 after `mthi` 0x1234 and `mtlo` 0x5678 → `busy` 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- Stall: `mult` start with `D_isMD`=1 held → `md_stall`=1 for exactly 6 consecutive cycles, 0 on the 7th. With `D_isMD`=0 → `md_stall` stays 0 throughout.
- Reset asserted asynchronously at busy cycle 3 of a `div` → `busy`, hi and lo go to 0 without waiting for a clock edge. No late commit after reset deasserts.
- `mtlo` 0xDEADBEEF → lo=0xDEADBEEF one cycle later, `busy` never asserts.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and the FSM state type.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu,
// plus a divide-by-zero flag.
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [31:0]        b_safe;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic               overflow;

    // Substitute a harmless divisor so the dividers never see zero;
    // the result is discarded by the caller in that case anyway.
    assign div_zero = (b == '0);
    assign b_safe   = div_zero ? 32'd1 : b;
    assign overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the arithmetic result for the requested op.
    always_comb begin
        result = '0;
        sq     = '0;
        sr     = '0;
        case (op)
            MD_MULT:  result = 64'($signed(a)) * 64'($signed(b));
            MD_MULTU: result = 64'(a) * 64'(b);
            MD_DIV: begin
                // Most-negative / -1 overflows the quotient; pin the MIPS result.
                if (overflow) begin
                    result = {32'h0000_0000, 32'h8000_0000};
                end else begin
                    sq     = $signed(a) / $signed(b_safe);
                    sr     = $signed(a) % $signed(b_safe);
                    result = {sr, sq};
                end
            end
            MD_DIVU:  result = {a % b_safe, a / b_safe};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at start, held pending, and committed after the
// fixed latency; md_stall keeps MD-class instructions out of E meanwhile.
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_mdOp,
    input  logic        E_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_isMD,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    md_state_t   state;
    logic [3:0]  cnt;
    logic [63:0] pending;
    logic        pending_valid;
    logic [63:0] arith_result;
    logic        arith_div_zero;

    md_arith u_arith (
        .op       (E_mdOp),
        .a        (E_A),
        .b        (E_B),
        .result   (arith_result),
        .div_zero (arith_div_zero)
    );

    assign busy     = (state == BUSY);
    assign md_stall = D_isMD & (E_start | busy);

    // FSM, latency counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            hi            <= '0;
            lo            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_start && is_mult_op(E_mdOp)) begin
                        pending       <= arith_result;
                        pending_valid <= 1'b1;
                        cnt           <= 4'(MULT_CYCLES);
                        state         <= BUSY;
                    end else if (E_start && is_div_op(E_mdOp)) begin
                        pending       <= arith_result;
                        pending_valid <= ~arith_div_zero;
                        cnt           <= 4'(DIV_CYCLES);
                        state         <= BUSY;
                    end else if (E_mdOp == MD_MTHI) begin
                        hi <= E_A;
                    end else if (E_mdOp == MD_MTLO) begin
                        lo <= E_A;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (pending_valid) begin
                            hi <= pending[63:32];
                            lo <= pending[31:0];
                        end
                        pending_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a timestamp-based behavioural
// model compared every cycle, plus literal expectations from hand math.
module tb_mult_div_unit;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  E_mdOp = '0;
    logic        E_start = 1'b0;
    logic [31:0] E_A = '0;
    logic [31:0] E_B = '0;
    logic        D_isMD = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(
        .MULT_CYCLES (N_MULT),
        .DIV_CYCLES  (N_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .E_mdOp   (E_mdOp),
        .E_start  (E_start),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_isMD   (D_isMD),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges; an operation started at edge k
    // is in flight until edge done_at = k+N, when its result lands.
    longint      cyc = 0;
    longint      done_at = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_ok = 1'b0;

    // Returns {valid, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb, q;
        logic [31:0]     uq;
        model_calc = '0;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                model_calc = {1'b1, 64'(sp)};
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                model_calc = {1'b1, up};
            end
            OP_DIV: begin
                sa = a;
                sb = b;
                if (b == 0) model_calc = '0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model_calc = {1'b1, 32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    model_calc = {1'b1, 32'(sa - q * sb), 32'(q)};
                end
            end
            OP_DIVU: begin
                if (b == 0) model_calc = '0;
                else begin
                    uq = a / b;
                    model_calc = {1'b1, a - uq * b, uq};
                end
            end
            default: model_calc = '0;
        endcase
    endfunction

    logic [64:0] calc;
    always_comb calc = model_calc(E_mdOp, E_A, E_B);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi    <= '0;
            m_lo    <= '0;
            p_ok    <= 1'b0;
            done_at <= cyc;
        end else begin
            if (cyc < done_at) begin
                if (cyc + 1 == done_at && p_ok) begin
                    m_hi <= p_hi;
                    m_lo <= p_lo;
                end
            end else if (E_start && E_mdOp >= OP_MULT && E_mdOp <= OP_DIVU) begin
                p_ok    <= calc[64];
                p_hi    <= calc[63:32];
                p_lo    <= calc[31:0];
                done_at <= cyc + 1 + ((E_mdOp <= OP_MULTU) ? N_MULT : N_DIV);
            end else if (E_mdOp == OP_MTHI) begin
                m_hi <= E_A;
            end else if (E_mdOp == OP_MTLO) begin
                m_lo <= E_A;
            end
            cyc <= cyc + 1;
        end
    end

    always @(posedge clk) begin
        if (!reset) assert (!(E_start && cyc < done_at)) else $error("illegal E_start while busy");
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("busy", 32'(busy), 32'(cyc < done_at));
        chk("md_stall", 32'(md_stall), 32'(D_isMD && (E_start || cyc < done_at)));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic start, input logic [31:0] a,
                         input logic [31:0] b);
        E_mdOp  = op;
        E_start = start;
        E_A     = a;
        E_B     = b;
        step();
        E_mdOp  = OP_NONE;
        E_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    logic [6:0] stall_seen;
    logic [6:0] busy_seen;

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step();
        reset = 1'b0;
        step();

        // mult -1 * 3 with a D-stage MD instruction held behind it
        E_mdOp = OP_MULT; E_start = 1'b1; E_A = 32'hFFFF_FFFF; E_B = 32'd3; D_isMD = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            stall_seen[i] = md_stall;
            busy_seen[i]  = busy;
            step();
            E_start = 1'b0;
            E_mdOp  = OP_NONE;
        end
        D_isMD = 1'b0;
        chk("stall_cycles", 32'($countones(stall_seen[5:0])), 32'd6);
        chk("stall_7th", 32'(stall_seen[6]), 32'd0);
        chk("busy_cycles", 32'($countones(busy_seen)), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFD);

        issue(OP_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd3);
        idle(6);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFD);

        issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        idle(11);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIVU, 1'b1, 32'd7, 32'd2);
        idle(11);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(OP_MTHI, 1'b0, 32'h1234, 32'd0);
        issue(OP_MTLO, 1'b0, 32'h5678, 32'd0);
        issue(OP_DIV, 1'b1, 32'd99, 32'd0);
        idle(11);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);

        issue(OP_MTLO, 1'b0, 32'hDEAD_BEEF, 32'd0);
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        chk("mtlo_busy", 32'(busy), 32'd0);

        issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(11);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        issue(OP_NONE, 1'b1, 32'd5, 32'd5);
        chk("none_busy", 32'(busy), 32'd0);
        issue(3'd7, 1'b1, 32'd5, 32'd5);
        chk("op7_busy", 32'(busy), 32'd0);

        // Extra vectors checked by the model alone
        issue(OP_MULT,  1'b1, 32'h1234_5678, 32'h9ABC_DEF0); idle(6);
        issue(OP_MULTU, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF); idle(6);
        issue(OP_DIV,   1'b1, 32'd7,         32'hFFFF_FFFE); idle(11);
        issue(OP_DIV,   1'b1, 32'h8000_0001, 32'd7);         idle(11);
        issue(OP_DIVU,  1'b1, 32'hFFFF_FFFF, 32'd10);        idle(11);

        // Asynchronous reset in the middle of a divide
        issue(OP_MTHI, 1'b0, 32'hCAFE_0001, 32'd0);
        issue(OP_DIV, 1'b1, 32'd100, 32'd7);
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_hi", hi, 32'h0);
        chk("async_lo", lo, 32'h0);
        step();
        reset = 1'b0;
        idle(14);
        chk("late_hi", hi, 32'h0);
        chk("late_lo", lo, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
